aquila_data_router: RTL and testbench

//  Parametrised data-side request router between the Aquila core data port and NUM_TGT slaves
//  (TCM, D-cache, device bus, CLINT, ...). Decodes each strobe against a base/mask region table.

---
 rtl/aquila_data_router_pkg.sv | 24 ++
 rtl/aquila_data_router_if.sv | 23 ++
 rtl/aquila_data_router_addr_region_decoder.sv | 36 +++
 rtl/aquila_data_router.sv | 153 +++++++++++++++
 tb/tb_aquila_data_router.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/aquila_data_router_pkg.sv
// rtl/aquila_data_router_pkg.sv - state encodings and default memory map for the data-side router
package aquila_data_router_pkg;

  localparam int DEF_XLEN    = 32;
  localparam int DEF_NUM_TGT = 4;
  localparam int DEF_TIMEOUT = 1024;

  // Target i occupies slice i; index 0 is the TCM at the bottom of the map.
  localparam logic [DEF_NUM_TGT*DEF_XLEN-1:0] DEF_TGT_BASE =
    {32'hF000_0000, 32'hC000_0000, 32'h8000_0000, 32'h0000_0000};
  localparam logic [DEF_NUM_TGT*DEF_XLEN-1:0] DEF_TGT_MASK =
    {32'hF000_0000, 32'hF000_0000, 32'hC000_0000, 32'hF000_0000};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } rtr_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aquila_data_router_if.sv
// rtl/aquila_data_router_if.sv - core data port bundle between the Aquila core and the data router
interface aquila_data_router_if #(
  parameter int XLEN = 32
);
  logic              req_i;
  logic [XLEN-1:0]   addr_i;
  logic              rw_i;
  logic [XLEN/8-1:0] be_i;
  logic [XLEN-1:0]   wdata_i;
  logic [XLEN-1:0]   rdata_o;
  logic              ready_o;
  logic              err_o;

  modport master (
    output req_i, addr_i, rw_i, be_i, wdata_i,
    input  rdata_o, ready_o, err_o
  );

  modport slave (
    input  req_i, addr_i, rw_i, be_i, wdata_i,
    output rdata_o, ready_o, err_o
  );
endinterface

// File: rtl/aquila_data_router_addr_region_decoder.sv
// rtl/aquila_data_router_addr_region_decoder.sv - combinational base/mask region decode with lowest-index priority
module aquila_data_router_addr_region_decoder
  import aquila_data_router_pkg::*;
#(
  parameter int                          XLEN     = DEF_XLEN,
  parameter int                          NUM_TGT  = DEF_NUM_TGT,
  parameter logic [NUM_TGT*XLEN-1:0]     TGT_BASE = DEF_TGT_BASE,
  parameter logic [NUM_TGT*XLEN-1:0]     TGT_MASK = DEF_TGT_MASK,
  localparam int                         IDX_W    = idx_width(NUM_TGT)
) (
  input  logic [XLEN-1:0]    addr_i,
  output logic [NUM_TGT-1:0] hit_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_hit_o
);

  always_comb begin
    hit_o = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      hit_o[i] = (addr_i & TGT_MASK[i*XLEN +: XLEN]) == TGT_BASE[i*XLEN +: XLEN];
    end
  end

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if (hit_o[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

  assign any_hit_o = |hit_o;

endmodule

// File: rtl/aquila_data_router.sv
// rtl/aquila_data_router.sv - data-side request router to NUM_TGT slaves; AQUILA_ROUTER_TIMEOUT_EN adds a hung-target timeout
module aquila_data_router
  import aquila_data_router_pkg::*;
#(
  parameter int                      XLEN     = DEF_XLEN,
  parameter int                      NUM_TGT  = DEF_NUM_TGT,
  parameter logic [NUM_TGT*XLEN-1:0] TGT_BASE = DEF_TGT_BASE,
  parameter logic [NUM_TGT*XLEN-1:0] TGT_MASK = DEF_TGT_MASK,
  parameter int                      TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  aquila_data_router_if.slave       core,
  output logic                      proto_err_o,
  output logic [NUM_TGT-1:0]        tgt_strobe_o,
  output logic [NUM_TGT-1:0]        tgt_rw_o,
  output logic [XLEN-1:0]           tgt_addr_o,
  output logic [XLEN/8-1:0]         tgt_be_o,
  output logic [XLEN-1:0]           tgt_wdata_o,
  input  logic [NUM_TGT*XLEN-1:0]   tgt_rdata_i,
  input  logic [NUM_TGT-1:0]        tgt_ready_i
);

  localparam int IDX_W = idx_width(NUM_TGT);

  if (NUM_TGT < 1 || NUM_TGT > 16) begin : g_bad_num_tgt
    $error("aquila_data_router: NUM_TGT must be in 1..16");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("aquila_data_router: TIMEOUT must be at least 2");
  end

  rtr_state_e         state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic               proto_err_q, proto_err_d;

  logic [NUM_TGT-1:0] hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               any_hit;

  logic [XLEN-1:0]    rdata;
  logic               ready;
  logic               err;

  logic [XLEN-1:0]    tgt_rdata_a [NUM_TGT];

`ifdef AQUILA_ROUTER_TIMEOUT_EN
  localparam int               TMR_W    = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  logic [TMR_W-1:0]            timer_q, timer_d;
`endif

  aquila_data_router_addr_region_decoder #(
    .XLEN     (XLEN),
    .NUM_TGT  (NUM_TGT),
    .TGT_BASE (TGT_BASE),
    .TGT_MASK (TGT_MASK)
  ) u_decoder (
    .addr_i    (core.addr_i),
    .hit_o     (hit),
    .idx_o     (hit_idx),
    .any_hit_o (any_hit)
  );

  for (genvar g = 0; g < NUM_TGT; g++) begin : g_unpack
    assign tgt_rdata_a[g] = tgt_rdata_i[g*XLEN +: XLEN];
  end

  // Strobe is the isolated lowest hit bit, so it always agrees with hit_idx.
  assign tgt_strobe_o = (core.req_i && state_q == ST_IDLE) ? (hit & (~hit + NUM_TGT'(1))) : '0;
  assign tgt_rw_o     = {NUM_TGT{core.rw_i}} & tgt_strobe_o;
  assign tgt_addr_o   = core.addr_i;
  assign tgt_be_o     = core.be_i;
  assign tgt_wdata_o  = core.wdata_i;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    proto_err_d = proto_err_q;
    ready       = 1'b0;
    err         = 1'b0;
    rdata       = '0;
`ifdef AQUILA_ROUTER_TIMEOUT_EN
    timer_d     = timer_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (core.req_i) begin
          if (any_hit) begin
            sel_d   = hit_idx;
            state_d = ST_WAIT;
`ifdef AQUILA_ROUTER_TIMEOUT_EN
            timer_d = '0;
`endif
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_WAIT: begin
        ready = tgt_ready_i[sel_q];
        if (ready) begin
          rdata   = tgt_rdata_a[sel_q];
          state_d = ST_IDLE;
        end
`ifdef AQUILA_ROUTER_TIMEOUT_EN
        else if (timer_q == TMR_LAST) begin
          state_d = ST_ERR;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
`endif
      end
      ST_ERR: begin
        ready   = 1'b1;
        err     = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (core.req_i && state_q != ST_IDLE) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      proto_err_q <= 1'b0;
`ifdef AQUILA_ROUTER_TIMEOUT_EN
      timer_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      proto_err_q <= proto_err_d;
`ifdef AQUILA_ROUTER_TIMEOUT_EN
      timer_q     <= timer_d;
`endif
    end
  end

  assign core.rdata_o = rdata;
  assign core.ready_o = ready;
  assign core.err_o   = err;
  assign proto_err_o  = proto_err_q;

endmodule

// File: tb/tb_aquila_data_router.sv
// tb/tb_aquila_data_router.sv - scoreboard bench for aquila_data_router
module tb_aquila_data_router;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   tgt_strobe, tgt_rw, tgt_ready;
  logic [31:0]  tgt_addr, tgt_wdata;
  logic [3:0]   tgt_be;
  logic [127:0] tgt_rdata;
  logic         proto_err;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc_n = 0;
  int   r;
  exp_t exp_q[$];

  aquila_data_router_if #(.XLEN(32)) bus ();

  aquila_data_router #(
    .XLEN    (32),
    .NUM_TGT (4),
    .TIMEOUT (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .core         (bus),
    .proto_err_o  (proto_err),
    .tgt_strobe_o (tgt_strobe),
    .tgt_rw_o     (tgt_rw),
    .tgt_addr_o   (tgt_addr),
    .tgt_be_o     (tgt_be),
    .tgt_wdata_o  (tgt_wdata),
    .tgt_rdata_i  (tgt_rdata),
    .tgt_ready_i  (tgt_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n++;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc_n);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic rw, input logic [3:0] be, input logic [31:0] wd);
    bus.req_i   = 1'b1;
    bus.addr_i  = addr;
    bus.rw_i    = rw;
    bus.be_i    = be;
    bus.wdata_i = wd;
  endtask

  task automatic push_exp(input int due, input logic [31:0] rd, input logic e);
    exp_q.push_back('{due, rd, e});
  endtask

  // Response monitor: every ready_o must match the oldest outstanding expectation in cycle and data.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ready_o) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_ready", 32'd1, 32'd0);
        end else begin
          check_val("resp_cycle", cyc_n, exp_q[0].cyc);
          check_val("resp_rdata", bus.rdata_o, exp_q[0].rdata);
          check_val("resp_err", bus.err_o, exp_q[0].err);
          exp_q.delete(0);
        end
      end else begin
        check_val("idle_rdata", bus.rdata_o, 32'd0);
        check_val("idle_err", bus.err_o, 32'd0);
        if (exp_q.size() > 0 && cyc_n > exp_q[0].cyc) begin
          check_val("resp_missing", cyc_n, exp_q[0].cyc);
          exp_q.delete(0);
        end
      end
    end
  end

  initial begin
    bus.req_i = 1'b0; bus.addr_i = '0; bus.rw_i = 1'b0; bus.be_i = '0; bus.wdata_i = '0;
    tgt_ready = '0;
    tgt_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};

    nxt(); nxt();
    @(negedge clk);
    check_val("rst_ready", bus.ready_o, 32'd0);
    check_val("rst_err", bus.err_o, 32'd0);
    check_val("rst_rdata", bus.rdata_o, 32'd0);
    check_val("rst_proto", proto_err, 32'd0);
    check_val("rst_strobe", tgt_strobe, 32'd0);
    nxt();
    rst = 1'b0;
    nxt();

    // 1: read from tgt0, ready two cycles later
    drive_req(32'h0000_0100, 1'b0, 4'hF, 32'h0);
    push_exp(cyc_n + 2, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    check_val("t1_strobe", tgt_strobe, 32'h1);
    check_val("t1_rw", tgt_rw, 32'h0);
    check_val("t1_addr", tgt_addr, 32'h0000_0100);
    nxt();
    bus.req_i = 1'b0;
    @(negedge clk);
    check_val("t1_strobe_once", tgt_strobe, 32'h0);
    nxt();
    tgt_ready = 4'b0001;
    nxt();
    tgt_ready = 4'b0000;

    // 2: unmapped, issued back-to-back in the IDLE cycle after ready_o
    drive_req(32'hE000_0000, 1'b0, 4'hF, 32'h0);
    push_exp(cyc_n + 1, 32'h0, 1'b1);
    @(negedge clk);
    check_val("t2_strobe", tgt_strobe, 32'h0);
    nxt();
    bus.req_i = 1'b0;
    nxt();

    // 3: write to tgt2; readies in the request cycle and from tgt1 are ignored
    drive_req(32'hC000_0010, 1'b1, 4'b0011, 32'hA1B2_C3D4);
    tgt_ready = 4'b0110;
    tgt_rdata[64 +: 32] = 32'h1234_5678;
    @(negedge clk);
    check_val("t3_strobe", tgt_strobe, 32'h4);
    check_val("t3_rw", tgt_rw, 32'h4);
    check_val("t3_be", tgt_be, 32'h3);
    check_val("t3_wdata", tgt_wdata, 32'hA1B2_C3D4);
    nxt();
    bus.req_i = 1'b0; bus.rw_i = 1'b0;
    tgt_ready = 4'b0010;
    nxt();
    tgt_ready = 4'b0000;
    nxt();
    tgt_ready = 4'b0100;
    push_exp(cyc_n, 32'h1234_5678, 1'b0);
    nxt();
    tgt_ready = 4'b0000;

    // 4: second request while busy is dropped and raises sticky proto_err_o
    drive_req(32'hF000_0004, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    check_val("t4_strobe", tgt_strobe, 32'h8);
    check_val("t4_proto_pre", proto_err, 32'd0);
    nxt();
    drive_req(32'h0000_0200, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    check_val("t4_drop_strobe", tgt_strobe, 32'h0);
    nxt();
    bus.req_i = 1'b0;
    @(negedge clk);
    check_val("t4_proto_set", proto_err, 32'd1);
    nxt();
    tgt_ready = 4'b1000;
    push_exp(cyc_n, 32'h3333_3333, 1'b0);
    nxt();
    tgt_ready = 4'b0000;
    nxt();
    @(negedge clk);
    check_val("t4_proto_sticky", proto_err, 32'd1);

    // 6: reset while waiting on tgt0; the late ready afterwards is discarded
    nxt();
    drive_req(32'h0000_0040, 1'b0, 4'hF, 32'h0);
    nxt();
    bus.req_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_val("t6_rst_ready", bus.ready_o, 32'd0);
    check_val("t6_rst_proto", proto_err, 32'd0);
    nxt();
    rst = 1'b0;
    tgt_ready = 4'b0001;
    @(negedge clk);
    check_val("t6_late_ready", bus.ready_o, 32'd0);
    nxt();
    tgt_ready = 4'b0000;
    drive_req(32'h8000_0000, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    check_val("t6_strobe", tgt_strobe, 32'h2);
    nxt();
    bus.req_i = 1'b0;
    tgt_rdata[32 +: 32] = 32'hCAFE_F00D;
    tgt_ready = 4'b0010;
    push_exp(cyc_n, 32'hCAFE_F00D, 1'b0);
    nxt();
    tgt_ready = 4'b0000;

`ifdef AQUILA_ROUTER_TIMEOUT_EN
    // 5: tgt0 never answers; timeout error 9 cycles after request, late ready discarded
    drive_req(32'h0000_0080, 1'b0, 4'hF, 32'h0);
    r = cyc_n;
    push_exp(r + 9, 32'h0, 1'b1);
    nxt();
    bus.req_i = 1'b0;
    while (cyc_n < r + 10) nxt();
    tgt_ready = 4'b0001;
    @(negedge clk);
    check_val("t5_late_ready", bus.ready_o, 32'd0);
    nxt();
    tgt_ready = 4'b0000;
`else
    // 5: without timeout, WAIT holds until the target finally answers
    drive_req(32'h0000_0080, 1'b0, 4'hF, 32'h0);
    r = cyc_n;
    nxt();
    bus.req_i = 1'b0;
    while (cyc_n < r + 20) nxt();
    tgt_ready = 4'b0001;
    push_exp(cyc_n, 32'hDEAD_BEEF, 1'b0);
    nxt();
    tgt_ready = 4'b0000;
`endif

    nxt(); nxt();
    @(negedge clk);
    check_val("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
